instruction_fetch_stage: RTL and testbench
==========================================

// Module: instruction_fetch_stage
// PURPOSE
//  IF stage: producer side of the IF/ID interface consumed by the decode stage. Owns the PC.
//  Fetches from instruction memory over a req/ready + rvalid handshake and fills the IF/ID register.
//  Obeys HDU stalls and EX-stage branch flushes.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  NOP_INSTR  32'h0000_0013  bubble word (addi x0,x0,0) driven into IF/ID on reset/flush
// PORTS
//  i_clk               in   1   clock, rising edge
//  i_reset             in   1   asynchronous, active-low reset
//  i_pc_write          in   1   HDU: 1 = PC may advance
//  i_if_id_write       in   1   HDU: 1 = IF/ID may load
//  i_flush             in   1   EX branch taken: redirect fetch, kill IF/ID
//  i_branch_target     in   32  redirect PC, sampled when i_flush=1
//  o_imem_req          out  1   fetch request valid
//  o_imem_addr         out  32  fetch address (= PC)
//  i_imem_ready        in   1   imem accepts request this cycle
//  i_imem_rvalid       in   1   fetch response valid
//  i_imem_rdata        in   32  fetched instruction
//  o_if_id_pc          out  32  IF/ID PC
//  o_if_id_instruction out  32  IF/ID instruction
//  o_if_id_valid       out  1   IF/ID holds a real instruction
// BEHAVIOUR
//  Reset (i_reset=0, async): state=IDLE, pc=RESET_PC, o_if_id_pc=0, o_if_id_instruction=NOP_INSTR,
//   o_if_id_valid=0, hold buffer=0. o_imem_req=0 in IDLE; o_imem_addr=pc at all times.
//  stall = ~i_pc_write | ~i_if_id_write. At most one request outstanding.
//  FSM (registered state, 5 states):
//   IDLE : ->REQ next cycle.
//   REQ  : o_imem_req=1. ready=1 -> WAIT; flush&ready -> DRAIN; flush&~ready -> REQ.
//   WAIT : rvalid&~stall -> IF/ID <= {pc,rdata,valid=1}, pc<=pc+4, ->REQ.
//          rvalid&stall  -> hold buffer<=rdata, ->HOLD. No rvalid -> stay.
//   HOLD : ~stall -> IF/ID <= {pc,buffer,1}, pc<=pc+4, ->REQ. stall -> stay.
//   DRAIN: wait for rvalid; discard rdata; ->REQ.
//  IF/ID when not loaded with an instruction: if i_if_id_write=1 load bubble
//   (pc unchanged, NOP_INSTR, valid=0); if i_if_id_write=0 hold contents.
//  Flush (highest priority, any state except IDLE): pc<=i_branch_target; IF/ID<=bubble
//   regardless of stall; WAIT/HOLD with rvalid same cycle -> data dropped, ->REQ;
//   WAIT without rvalid -> DRAIN; HOLD -> REQ (buffer discarded).
//  Flush during DRAIN: pc<=new target, stay DRAIN.
//  PC arithmetic: 32-bit unsigned +4, wraps 32'hFFFF_FFFC -> 0. Target taken as-is (no alignment check).
//  Latency: reset release -> req on 2nd edge; ready=1,rvalid next cycle -> IF/ID valid 1 edge after
//   rvalid. Throughput 1 instr / 2 cycles with zero-wait imem.
//  Reset mid-transaction: all state cleared; a late rvalid after reset is ignored (arrives in IDLE/REQ).
//  rvalid in IDLE/REQ is ignored.
// TESTING
//  1 Reset release, ready=1, rvalid 1 cycle after accept, rdata=0x00500093 ->
//    IF/ID {0x0,0x00500093,1}; next req addr 0x4.
//  2 i_if_id_write=0,i_pc_write=0 during rvalid of addr 0x8 -> HOLD, IF/ID unchanged 3 cycles;
//    release -> IF/ID {0x8,word,1}, pc=0xC.
//  3 i_flush=1, target 0x100 while in WAIT, rvalid 2 cycles later -> IF/ID valid=0, data dropped,
//    next req addr 0x100.
//  4 Flush coincident with rvalid and with stall -> bubble loaded, next addr = target, no HOLD.
//  5 Imem ready delayed 4 cycles -> req held, addr stable at pc; no duplicate fetch.
//  6 RESET_PC=32'hFFFF_FFFC -> first fetch 0xFFFFFFFC, next 0x0; reset asserted in WAIT -> outputs
//    at reset values immediately, late rvalid ignored.

Source files
------------

// File: rtl/instruction_fetch_stage_if.sv
// Instruction-memory fetch bus: one request (req/addr accepted on ready)
// followed later by one response (rvalid/rdata).
interface instruction_fetch_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;

    // Fetch stage side: issues requests, consumes responses.
    modport master (output req, output addr, input ready, input rvalid, input rdata);
    // Memory side: accepts requests, returns responses.
    modport slave  (input req, input addr, output ready, output rvalid, output rdata);
endinterface

// File: rtl/instruction_fetch_stage.sv
// IF stage: owns the PC, fetches one instruction at a time from imem and
// fills the IF/ID register. Honours HDU stalls and EX-stage flushes.
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_pc_write,
    input  logic                        i_if_id_write,
    input  logic                        i_flush,
    input  logic [31:0]                 i_branch_target,
    instruction_fetch_stage_if.master   imem,
    output logic [31:0]                 o_if_id_pc,
    output logic [31:0]                 o_if_id_instruction,
    output logic                        o_if_id_valid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DRAIN
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] if_id_pc_d, if_id_instr_d;
    logic        if_id_valid_d;
    logic        stall;
    logic        flush_act;
    logic        load;
    logic [31:0] load_word;

    assign stall     = ~i_pc_write | ~i_if_id_write;
    // Flush is meaningless before the first request has been issued.
    assign flush_act = i_flush & (state_q != S_IDLE);

    assign imem.req  = (state_q == S_REQ);
    assign imem.addr = pc_q;

    // Next-state, PC and hold-buffer logic.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        hold_d    = hold_q;
        load      = 1'b0;
        load_word = imem.rdata;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (flush_act)       state_d = imem.ready ? S_DRAIN : S_REQ;
                else if (imem.ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (flush_act) begin
                    // Response already here is dropped; otherwise it must be drained.
                    state_d = imem.rvalid ? S_REQ : S_DRAIN;
                end else if (imem.rvalid) begin
                    if (!stall) begin
                        load    = 1'b1;
                        state_d = S_REQ;
                    end else begin
                        hold_d  = imem.rdata;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (flush_act) begin
                    state_d = S_REQ;
                end else if (!stall) begin
                    load      = 1'b1;
                    load_word = hold_q;
                    state_d   = S_REQ;
                end
            end
            S_DRAIN: begin
                // A further flush only retargets the PC; the stale response
                // still has to come back before a new request goes out.
                if (imem.rvalid) state_d = S_REQ;
            end
            default: state_d = S_IDLE;
        endcase
        if (flush_act)  pc_d = i_branch_target;
        else if (load)  pc_d = pc_q + 32'd4;
    end

    // IF/ID next value: flush bubble beats everything, then a fetched word,
    // then a plain bubble when the HDU lets IF/ID load.
    always_comb begin
        if_id_pc_d    = o_if_id_pc;
        if_id_instr_d = o_if_id_instruction;
        if_id_valid_d = o_if_id_valid;
        if (flush_act) begin
            if_id_instr_d = NOP_INSTR;
            if_id_valid_d = 1'b0;
        end else if (load) begin
            if_id_pc_d    = pc_q;
            if_id_instr_d = load_word;
            if_id_valid_d = 1'b1;
        end else if (i_if_id_write) begin
            if_id_instr_d = NOP_INSTR;
            if_id_valid_d = 1'b0;
        end
    end

    // State, PC, hold buffer and IF/ID registers.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q             <= S_IDLE;
            pc_q                <= RESET_PC;
            hold_q              <= 32'h0;
            o_if_id_pc          <= 32'h0;
            o_if_id_instruction <= NOP_INSTR;
            o_if_id_valid       <= 1'b0;
        end else begin
            state_q             <= state_d;
            pc_q                <= pc_d;
            hold_q              <= hold_d;
            o_if_id_pc          <= if_id_pc_d;
            o_if_id_instruction <= if_id_instr_d;
            o_if_id_valid       <= if_id_valid_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Randomised + directed bench for instruction_fetch_stage. Two DUTs share
// all stimulus; they differ only in RESET_PC (0 and 32'hFFFF_FFFC).
module tb_instruction_fetch_stage;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] RPC1 = 32'hFFFF_FFFC;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_pc_write, i_if_id_write, i_flush;
    logic [31:0] i_branch_target;
    logic [31:0] pc0, ins0, pc1, ins1;
    logic        v0, v1;

    instruction_fetch_stage_if imem0 ();
    instruction_fetch_stage_if imem1 ();

    instruction_fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut0 (
        .i_clk(i_clk), .i_reset(i_reset), .i_pc_write(i_pc_write),
        .i_if_id_write(i_if_id_write), .i_flush(i_flush),
        .i_branch_target(i_branch_target), .imem(imem0),
        .o_if_id_pc(pc0), .o_if_id_instruction(ins0), .o_if_id_valid(v0));

    instruction_fetch_stage #(.RESET_PC(RPC1), .NOP_INSTR(NOP)) dut1 (
        .i_clk(i_clk), .i_reset(i_reset), .i_pc_write(i_pc_write),
        .i_if_id_write(i_if_id_write), .i_flush(i_flush),
        .i_branch_target(i_branch_target), .imem(imem1),
        .o_if_id_pc(pc1), .o_if_id_instruction(ins1), .o_if_id_valid(v1));

    always #5 i_clk = ~i_clk;

    // Transaction-level model: tracks whether a request is in flight, whether
    // its response is to be discarded, and a word parked by a stall.
    typedef struct {
        logic        started;
        logic        outst;
        logic        drop;
        logic        held_v;
        logic [31:0] held;
        logic [31:0] pc;
        logic [31:0] ifpc;
        logic [31:0] ifins;
        logic        ifv;
    } mdl_t;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic [31:0] ifpc;
        logic [31:0] ifins;
        logic        ifv;
    } exp_t;

    mdl_t m0, m1;
    exp_t q0[$], q1[$];
    int   checks = 0;
    int   errors = 0;

    function automatic mdl_t mdl_reset(input logic [31:0] rpc);
        mdl_t m;
        m.started = 0; m.outst = 0; m.drop = 0; m.held_v = 0; m.held = 0;
        m.pc = rpc; m.ifpc = 0; m.ifins = NOP; m.ifv = 0;
        return m;
    endfunction

    function automatic logic mdl_req(input mdl_t m);
        return m.started && !m.outst && !m.held_v;
    endfunction

    function automatic mdl_t mdl_step(input mdl_t m, input logic pcw, input logic ifw,
                                      input logic fl, input logic [31:0] tgt,
                                      input logic rdy, input logic rv, input logic [31:0] rd);
        mdl_t n = m;
        logic stall = !pcw || !ifw;
        logic wrote = 0;
        logic [31:0] w = rd;
        logic take = 0;
        if (!m.started) begin
            n.started = 1;
        end else if (fl) begin
            n.pc = tgt; n.held_v = 0;
            n.ifins = NOP; n.ifv = 0; wrote = 1;
            if (m.outst) begin
                if (rv) begin n.outst = 0; n.drop = 0; end
                else n.drop = 1;
            end else if (mdl_req(m) && rdy) begin
                n.outst = 1; n.drop = 1;
            end
        end else if (m.outst) begin
            if (rv) begin
                n.outst = 0;
                if (m.drop) n.drop = 0;
                else if (!stall) take = 1;
                else begin n.held_v = 1; n.held = rd; end
            end
        end else if (m.held_v) begin
            if (!stall) begin take = 1; w = m.held; n.held_v = 0; end
        end else if (rdy) begin
            n.outst = 1; n.drop = 0;
        end
        if (take) begin
            n.ifpc = m.pc; n.ifins = w; n.ifv = 1; n.pc = m.pc + 32'd4; wrote = 1;
        end
        if (!wrote && ifw) begin n.ifins = NOP; n.ifv = 0; end
        return n;
    endfunction

    function automatic exp_t to_exp(input mdl_t m);
        exp_t e;
        e.req = mdl_req(m); e.addr = m.pc; e.ifpc = m.ifpc; e.ifins = m.ifins; e.ifv = m.ifv;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, a, e);
        end
    endtask

    // Called at a negedge: drive inputs for the next rising edge, advance the
    // model, queue the expected post-edge outputs, then wait one cycle.
    task automatic cyc(input logic pcw, input logic ifw, input logic fl, input logic [31:0] tgt,
                       input logic rdy, input logic rv, input logic [31:0] rd);
        i_pc_write = pcw; i_if_id_write = ifw; i_flush = fl; i_branch_target = tgt;
        imem0.ready = rdy; imem0.rvalid = rv; imem0.rdata = rd;
        imem1.ready = rdy; imem1.rvalid = rv; imem1.rdata = rd;
        m0 = mdl_step(m0, pcw, ifw, fl, tgt, rdy, rv, rd);
        m1 = mdl_step(m1, pcw, ifw, fl, tgt, rdy, rv, rd);
        q0.push_back(to_exp(m0));
        q1.push_back(to_exp(m1));
        @(negedge i_clk);
    endtask

    task automatic idle_in();
        i_pc_write = 1; i_if_id_write = 1; i_flush = 0; i_branch_target = 0;
        imem0.ready = 0; imem0.rvalid = 0; imem0.rdata = 0;
        imem1.ready = 0; imem1.rvalid = 0; imem1.rdata = 0;
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_req0"},  {31'h0, imem0.req}, 32'h0);
        chk({nm, "_addr0"}, imem0.addr, 32'h0);
        chk({nm, "_addr1"}, imem1.addr, RPC1);
        chk({nm, "_pc0"},   pc0, 32'h0);
        chk({nm, "_ins0"},  ins0, NOP);
        chk({nm, "_v0"},    {31'h0, v0}, 32'h0);
        chk({nm, "_v1"},    {31'h0, v1}, 32'h0);
    endtask

    // Monitor: compares every queued expectation just after the edge it describes.
    initial begin
        exp_t e;
        forever begin
            @(posedge i_clk);
            #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chk("req0",  {31'h0, imem0.req}, {31'h0, e.req});
                chk("addr0", imem0.addr, e.addr);
                chk("ifpc0", pc0, e.ifpc);
                chk("ins0",  ins0, e.ifins);
                chk("v0",    {31'h0, v0}, {31'h0, e.ifv});
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("req1",  {31'h0, imem1.req}, {31'h0, e.req});
                chk("addr1", imem1.addr, e.addr);
                chk("ifpc1", pc1, e.ifpc);
                chk("ins1",  ins1, e.ifins);
                chk("v1",    {31'h0, v1}, {31'h0, e.ifv});
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // Stimulus.
    initial begin
        logic [31:0] w;
        logic rdy, rv, fl, pcw, ifw;
        idle_in();
        i_reset = 0;
        m0 = mdl_reset(32'h0);
        m1 = mdl_reset(RPC1);
        repeat (2) @(negedge i_clk);
        chk_reset_vals("rst");
        i_reset = 1;

        // 1: first fetch.
        cyc(1, 1, 0, 0, 0, 0, 0);
        chk("t1_req_addr0", imem0.addr, 32'h0);
        chk("t6_first_addr1", imem1.addr, RPC1);
        cyc(1, 1, 0, 0, 1, 0, 0);
        cyc(1, 1, 0, 0, 0, 1, 32'h0050_0093);
        chk("t1_ifpc", pc0, 32'h0);
        chk("t1_ins", ins0, 32'h0050_0093);
        chk("t1_v", {31'h0, v0}, 32'h1);
        chk("t1_next_addr", imem0.addr, 32'h4);
        chk("t6_wrap_addr1", imem1.addr, 32'h0);

        // 2: stall while the response for 0x8 lands.
        cyc(1, 1, 0, 0, 1, 0, 0);
        cyc(1, 1, 0, 0, 0, 1, 32'h1111_1111);
        cyc(1, 1, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 32'h2222_2222);
        repeat (3) cyc(0, 0, 0, 0, 1, 0, 0);
        chk("t2_hold_ifpc", pc0, 32'h4);
        chk("t2_hold_v", {31'h0, v0}, 32'h0);
        chk("t2_no_req", {31'h0, imem0.req}, 32'h0);
        cyc(1, 1, 0, 0, 0, 0, 0);
        chk("t2_ifpc", pc0, 32'h8);
        chk("t2_ins", ins0, 32'h2222_2222);
        chk("t2_pc", imem0.addr, 32'hC);

        // 3: flush in WAIT, response arrives two cycles later and is dropped.
        cyc(1, 1, 0, 0, 1, 0, 0);
        cyc(1, 1, 1, 32'h100, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 1, 32'hDEAD_BEEF);
        chk("t3_v", {31'h0, v0}, 32'h0);
        chk("t3_req", {31'h0, imem0.req}, 32'h1);
        chk("t3_addr", imem0.addr, 32'h100);

        // 4: flush with rvalid and stall together.
        cyc(1, 1, 0, 0, 1, 0, 0);
        cyc(0, 0, 1, 32'h200, 0, 1, 32'hBAD0_BAD0);
        chk("t4_ins", ins0, NOP);
        chk("t4_req", {31'h0, imem0.req}, 32'h1);
        chk("t4_addr", imem0.addr, 32'h200);

        // 5: imem not ready for 4 cycles.
        repeat (4) cyc(1, 1, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 1, 0, 0);
        cyc(1, 1, 0, 0, 1, 0, 0);
        cyc(1, 1, 0, 0, 0, 1, 32'h3333_3333);
        chk("t5_ifpc", pc0, 32'h200);
        chk("t5_ins", ins0, 32'h3333_3333);

        // 6: reset asserted while in WAIT, late rvalid afterwards.
        cyc(1, 1, 0, 0, 1, 0, 0);
        #2 i_reset = 0;
        #1 chk_reset_vals("t6_rst");
        m0 = mdl_reset(32'h0);
        m1 = mdl_reset(RPC1);
        @(negedge i_clk);
        i_reset = 1;
        cyc(1, 1, 0, 0, 0, 1, 32'h4444_4444);
        cyc(1, 1, 0, 0, 0, 1, 32'h4444_4444);
        chk("t6_late_v", {31'h0, v0}, 32'h0);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            pcw = ($urandom_range(0, 3) != 0);
            ifw = ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 11) == 0);
            rdy = ($urandom_range(0, 1) == 1);
            rv  = m0.outst ? ($urandom_range(0, 4) < 2) : ($urandom_range(0, 9) == 0);
            w   = $urandom;
            cyc(pcw, ifw, fl, $urandom, rdy, rv, w);
        end

        repeat (2) @(negedge i_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
